regfile_sb: RTL
===============

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter XLEN, default 32, data width in bits.
REQ-002 Parameter NREG, default 32, register count; power of two, 2..64; AW = log2(NREG).
REQ-003 Parameter NRP, default 2, read port count, 1..4.
REQ-004 Port clk  in  1  single clock; all state updates on rising edge.
REQ-005 Port rst  in  1  reset, synchronous, active-high.
REQ-006 Port rd_addr  in  NRP*AW  read addresses; port k occupies bits [k*AW +: AW].
REQ-007 Port rd_data  out  NRP*XLEN  read data per port.
REQ-008 Port rd_rdy  out  NRP  per-port operand-valid flag (no pending producer).
REQ-009 Port wb0_en / wb0_addr / wb0_data  in  1/AW/XLEN  write port 0.
REQ-010 Port wb1_en / wb1_addr / wb1_data  in  1/AW/XLEN  write port 1; higher priority than port 0.
REQ-011 Port iss_en / iss_rd  in  1/AW  issue: marks iss_rd as having a pending producer.
REQ-012 Port busy  out  NREG  scoreboard bit vector, registered.
REQ-013 Port busy_cnt  out  AW+1  number of set busy bits, registered.

Function
REQ-014 Register 0 SHALL read as 0 on every port, is never written, and is never marked busy.
REQ-015 Reads SHALL be combinational, zero-latency.
REQ-016 Read bypass priority: wb1 (en, addr match, addr!=0) > wb0 (same) > array contents.
REQ-017 Writes SHALL update the array at the rising edge; wb0 and wb1 to the same nonzero address in one cycle -> wb1 data stored, wb0 dropped.
REQ-018 rd_rdy[k] = 1 when addr is 0, when busy[addr]=0, or when addr is written this cycle by either write port; else 0.
REQ-019 Scoreboard next state per register r!=0: set if iss_en and iss_rd==r; else clear if any write port writes r; else hold.
REQ-020 Issue and write to the same register in one cycle SHALL leave busy=1 (new producer wins); the write data is still stored.
REQ-021 Issue to a register already busy SHALL keep it busy (no error, no count change).
REQ-022 A write to a non-busy register SHALL store data and leave busy=0.
REQ-023 busy_cnt SHALL equal the popcount of busy after every edge; range 0..NREG-1, no wrap.
REQ-024 While rst=1: rd_data=0 and rd_rdy=0 on all ports, regardless of inputs.

Reset
REQ-025 On a rising edge with rst=1: all array entries = 0, busy = 0, busy_cnt = 0; write and issue inputs in that cycle are ignored.
REQ-026 Reset asserted mid-operation SHALL discard all pending busy state in the same edge; the first edge after rst deasserts behaves as a normal cycle.

Structure
REQ-027 Shared package regfile_pkg SHALL hold the AW derivation function, the default XLEN/NREG/NRP constants, and the register-0 address constant.
REQ-028 One sub-module regfile_sb_rdport SHALL implement a single read port (x0 check, two-level bypass, rdy); it is instantiated NRP times in a generate loop.
REQ-029 busy_cnt SHALL be maintained incrementally (+1/-1/0 per edge from the set/clear events, summed over registers), not by a combinational popcount on the output.

Verification
REQ-030 Reset then read all addresses -> rd_data=0, busy=0, busy_cnt=0.
REQ-031 wb0 write r5=0xDEADBEEF while rd_addr[0]=5 -> same-cycle rd_data=0xDEADBEEF; next cycle, with no write, it still reads 0xDEADBEEF.
REQ-032 wb0 r7=0x11 and wb1 r7=0x22 in one cycle -> bypass 0x22; array holds 0x22 afterwards.
REQ-033 iss r3 -> busy[3]=1, busy_cnt=1, rd_rdy=0 for r3; wb1 r3=0x5 -> rd_rdy=1 in the same cycle, busy[3]=0 and busy_cnt=0 at the next edge.
REQ-034 iss r9 and wb0 r9=0xA in one cycle -> busy[9]=1, array r9=0xA; iss to x0 and write x0=0xFF -> busy[0]=0, reads 0.
REQ-035 Busy r1..r4, then rst=1 for one cycle -> busy=0, busy_cnt=0, all registers 0; a write issued together with rst is not stored.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
package regfile_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned NREG_DEF = 32;
  localparam int unsigned NRP_DEF  = 2;
  localparam int unsigned REG_ZERO = 0;

  // Address width for a power-of-two register count (2..64 supported).
  function automatic int unsigned calc_aw(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 7; i++) begin
      if ((32'd1 << i) < n) begin
        w = i + 1;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/regfile_sb_rdport.sv
// One combinational read port: x0 forcing, two-level write bypass, operand ready.
module regfile_sb_rdport
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned AW   = 5
) (
  input  logic            rst,
  input  logic [AW-1:0]   rd_addr,
  input  logic [XLEN-1:0] arr_data,
  input  logic            busy_bit,
  input  logic            wb0_en,
  input  logic [AW-1:0]   wb0_addr,
  input  logic [XLEN-1:0] wb0_data,
  input  logic            wb1_en,
  input  logic [AW-1:0]   wb1_addr,
  input  logic [XLEN-1:0] wb1_data,
  output logic [XLEN-1:0] rd_data,
  output logic            rd_rdy
);

  localparam logic [AW-1:0] X0 = AW'(REG_ZERO);

  logic is_x0_s;
  logic hit0_s;
  logic hit1_s;

  assign is_x0_s = (rd_addr == X0);
  assign hit1_s  = wb1_en && (wb1_addr == rd_addr) && !is_x0_s;
  assign hit0_s  = wb0_en && (wb0_addr == rd_addr) && !is_x0_s;

  // Select read data and ready; a same-cycle writer always satisfies the operand.
  always_comb begin
    rd_data = '0;
    rd_rdy  = 1'b0;
    if (rst) begin
      rd_data = '0;
      rd_rdy  = 1'b0;
    end else if (is_x0_s) begin
      rd_data = '0;
      rd_rdy  = 1'b1;
    end else if (hit1_s) begin
      rd_data = wb1_data;
      rd_rdy  = 1'b1;
    end else if (hit0_s) begin
      rd_data = wb0_data;
      rd_rdy  = 1'b1;
    end else begin
      rd_data = arr_data;
      rd_rdy  = !busy_bit;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with two write-back ports, NRP bypassed read ports and a
// busy scoreboard whose population count is tracked incrementally.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int unsigned XLEN = XLEN_DEF,
  parameter  int unsigned NREG = NREG_DEF,
  parameter  int unsigned NRP  = NRP_DEF,
  localparam int unsigned AW   = calc_aw(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRP*AW-1:0]   rd_addr,
  output logic [NRP*XLEN-1:0] rd_data,
  output logic [NRP-1:0]      rd_rdy,
  input  logic                wb0_en,
  input  logic [AW-1:0]       wb0_addr,
  input  logic [XLEN-1:0]     wb0_data,
  input  logic                wb1_en,
  input  logic [AW-1:0]       wb1_addr,
  input  logic [XLEN-1:0]     wb1_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_rd,
  output logic [NREG-1:0]     busy,
  output logic [AW:0]         busy_cnt
);

  localparam logic [AW-1:0] X0 = AW'(REG_ZERO);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [AW:0]     busy_cnt_q;
  logic [AW:0]     busy_cnt_d;
  logic            inc_s;
  logic [1:0]      dec_s;

  // Array next state; wb1 is applied last so it wins a same-address collision.
  always_comb begin
    for (int unsigned r = 0; r < NREG; r++) begin
      regs_d[r] = regs_q[r];
    end
    if (wb0_en && (wb0_addr != X0)) begin
      regs_d[wb0_addr] = wb0_data;
    end else begin
      regs_d[0] = '0;
    end
    if (wb1_en && (wb1_addr != X0)) begin
      regs_d[wb1_addr] = wb1_data;
    end else begin
      regs_d[0] = '0;
    end
    regs_d[0] = '0;
  end

  // Scoreboard next state plus the +1/-1 events that keep the count exact.
  always_comb begin
    busy_d    = busy_q;
    busy_d[0] = 1'b0;
    inc_s     = 1'b0;
    dec_s     = 2'd0;
    for (int unsigned r = 1; r < NREG; r++) begin
      if (iss_en && (iss_rd == AW'(r))) begin
        busy_d[r] = 1'b1;
        inc_s     = inc_s | !busy_q[r];
      end else if ((wb0_en && (wb0_addr == AW'(r))) || (wb1_en && (wb1_addr == AW'(r)))) begin
        busy_d[r] = 1'b0;
        dec_s     = dec_s + {1'b0, busy_q[r]};
      end else begin
        busy_d[r] = busy_q[r];
      end
    end
    busy_cnt_d = busy_cnt_q + (AW+1)'(inc_s) - (AW+1)'(dec_s);
  end

  // State registers with synchronous reset that overrides all write/issue activity.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
      end
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      for (int unsigned r = 0; r < NREG; r++) begin
        regs_q[r] <= regs_d[r];
      end
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy     = busy_q;
  assign busy_cnt = busy_cnt_q;

  for (genvar k = 0; k < NRP; k++) begin : g_rd
    regfile_sb_rdport #(
      .XLEN(XLEN),
      .AW  (AW)
    ) u_rdport (
      .rst     (rst),
      .rd_addr (rd_addr[k*AW +: AW]),
      .arr_data(regs_q[rd_addr[k*AW +: AW]]),
      .busy_bit(busy_q[rd_addr[k*AW +: AW]]),
      .wb0_en  (wb0_en),
      .wb0_addr(wb0_addr),
      .wb0_data(wb0_data),
      .wb1_en  (wb1_en),
      .wb1_addr(wb1_addr),
      .wb1_data(wb1_data),
      .rd_data (rd_data[k*XLEN +: XLEN]),
      .rd_rdy  (rd_rdy[k])
    );
  end

endmodule
